sample_recorder: RTL and testbench
==================================

Name: sample_recorder

Overview:
- Parametrised successor to the mic-path recorder: single-clock audio block with mic passthrough, a record/playback buffer (inferred BRAM) and an optional boxcar low-pass filter on the output path.
- Sits between the mic PCM front end and the headphone PWM/DAC driver.
- Advances one sample per ready_in strobe, nominally at the audio sample rate within the 100 MHz domain.

Parameters:
- WIDTH, 8: signed PCM sample width in bits.
- DEPTH, 65536: buffer depth in samples; must be a power of two, >= 4.
- AVG_LOG2, 3: log2 of the boxcar filter length (2^AVG_LOG2 taps); range 1..5.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_n_in  input  1  asynchronous active-low reset.
- ready_in  input  1  one-cycle sample strobe; mic_in is valid on this cycle.
- record_in  input  1  level; request record mode.
- play_in  input  1  level; request playback mode.
- loop_in  input  1  level; in playback, wrap to start instead of stopping.
- filter_in  input  1  level; 1 selects the filtered output.
- mic_in  input  WIDTH  signed mic sample.
- data_out  output  WIDTH  signed sample to headphone.
- valid_out  output  1  one-cycle pulse when data_out updates.
- state_out  output  2  0 = IDLE, 1 = RECORD, 2 = PLAYBACK.
- length_out  output  $clog2(DEPTH)+1  number of recorded samples.
- full_out  output  1  the last recording hit DEPTH.

Behaviour:
- Reset (async assert, sync release) clears every output to 0, sets state IDLE, zeroes pointers, length, filter delay line and sum. Buffer contents are undefined after reset.
- FSM, evaluated each clock:
  - IDLE -> RECORD when record_in = 1. Clears wr_ptr, length and full_out.
  - IDLE -> PLAYBACK when record_in = 0, play_in = 1 and length > 0. Clears rd_ptr.
  - record_in takes priority over play_in.
  - RECORD -> IDLE when record_in = 0.
  - PLAYBACK -> IDLE when play_in = 0.
- Transition timing:
  - Any ready_in in the same cycle as a transition is processed under the pre-transition state.
  - A transition triggered by a ready_in write/read completes in that cycle.
- RECORD, on ready_in:
  - Write mic_in at wr_ptr, then increment wr_ptr and length.
  - If the write makes length = DEPTH: set full_out = 1 and go to IDLE the next cycle; no write ever wraps.
  - length is retained after RECORD exits; a new recording overwrites from address 0.
- PLAYBACK, on ready_in:
  - Read at rd_ptr. If rd_ptr = length-1: with loop_in = 1, rd_ptr <- 0; with loop_in = 0, go to IDLE after issuing this read.
  - Otherwise rd_ptr increments.
  - length = 1 with loop_in = 1 replays sample 0 indefinitely.
- Datapath, fixed 2-cycle latency for every state (ready_in at cycle t -> valid_out at t+2):
  - Stage 1: source sample = registered mic_in in IDLE/RECORD, BRAM read data in PLAYBACK (1-cycle sync read).
  - Stage 2: output register.
  - An in-flight read still emits its sample after the FSM has gone to IDLE.
- Filter:
  - Delay line of 2^AVG_LOG2 samples plus running sum of width WIDTH+AVG_LOG2, signed.
  - Updated on every stage-1 sample regardless of filter_in: sum <- sum + new - oldest.
  - Filtered value = sum >>> AVG_LOG2 (arithmetic shift, floor).
  - Cleared only by reset.
  - data_out = filtered when filter_in = 1, else the stage-1 sample; filter_in is sampled in stage 2.
- No overflow is possible (exact sum width); no saturation logic is required.

Decomposition:
- Package sample_recorder_pkg holds: state enum (IDLE, RECORD, PLAYBACK as 2-bit typedef) and the state_out encoding constants.
- Sub-module boxcar_filter (params WIDTH, AVG_LOG2; ports clk_in, rst_n_in, valid_in, sample_in, avg_out) holds the delay line and running sum.
- Buffer is an inferred single-port RAM inside sample_recorder.

Test Plan (WIDTH=8, DEPTH=16, AVG_LOG2=2):
- Passthrough: IDLE, ready_in with mic_in = 8'sd5, then 8'sd-7 -> valid_out pulses 2 cycles after each; data_out 5, then -7; state_out = 0.
- Record/play: record 4 samples {10, 20, -30, 40}, drop record_in, raise play_in with loop_in = 0 -> length_out = 4; outputs 10, 20, -30, 40; state_out returns to 0 after the 4th read; the 5th ready_in yields mic passthrough.
- Full: hold record_in over 20 ready_in strobes -> exactly 16 writes; full_out = 1; length_out = 16; state_out = 0 while record_in is still high; no new RECORD until record_in is deasserted and reasserted.
- Loop: length 3 {1, 2, 3}, play_in and loop_in high for 7 strobes -> 1, 2, 3, 1, 2, 3, 1.
- Filter: filter_in = 1; passthrough samples 4, 4, 4, 4, then -8 -> outputs 1, 2, 3, 4, then 1 ((4+4+4-8)>>>2); next -8 gives -2.
- Async reset: assert rst_n_in mid-PLAYBACK without a clock edge -> data_out, valid_out, state_out, length_out and full_out are 0 immediately; play_in afterwards does not enter PLAYBACK (length = 0).

Source files
------------

// File: rtl/sample_recorder_pkg.sv
// Shared state encoding for the sample recorder and its filter.
package sample_recorder_pkg;
  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_RECORD = 2'd1;
  localparam logic [1:0] STATE_PLAY   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = STATE_IDLE,
    ST_RECORD = STATE_RECORD,
    ST_PLAY   = STATE_PLAY
  } state_e;
endpackage

// File: rtl/boxcar_filter.sv
// Running-sum boxcar average over the last 2^AVG_LOG2 samples.
module boxcar_filter #(
  parameter int WIDTH    = 8,
  parameter int AVG_LOG2 = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] sample_in,
  output logic signed [WIDTH-1:0] avg_out
);
  localparam int TAPS = 1 << AVG_LOG2;
  localparam int SW   = WIDTH + AVG_LOG2;

  logic signed [WIDTH-1:0] r_dly [TAPS];
  logic signed [SW-1:0]    r_sum;
  logic        [SW-1:0]    w_sum_nxt;

  assign w_sum_nxt = r_sum
                   + {{AVG_LOG2{sample_in[WIDTH-1]}}, sample_in}
                   - {{AVG_LOG2{r_dly[TAPS-1][WIDTH-1]}}, r_dly[TAPS-1]};

  // Average includes the incoming sample; slicing above AVG_LOG2 is the floor shift.
  assign avg_out = w_sum_nxt[AVG_LOG2 +: WIDTH];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sum <= '0;
      for (int i = 0; i < TAPS; i++) r_dly[i] <= '0;
    end else if (valid_in) begin
      r_sum    <= w_sum_nxt;
      r_dly[0] <= sample_in;
      for (int i = 1; i < TAPS; i++) r_dly[i] <= r_dly[i-1];
    end
  end
endmodule

// File: rtl/sample_recorder.sv
// Mic passthrough / record / playback block with optional boxcar output filter.
module sample_recorder
  import sample_recorder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 65536,
  parameter int AVG_LOG2 = 3
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      ready_in,
  input  logic                      record_in,
  input  logic                      play_in,
  input  logic                      loop_in,
  input  logic                      filter_in,
  input  logic signed [WIDTH-1:0]   mic_in,
  output logic signed [WIDTH-1:0]   data_out,
  output logic                      valid_out,
  output logic [1:0]                state_out,
  output logic [$clog2(DEPTH):0]    length_out,
  output logic                      full_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_e                  r_state, w_state_nxt;
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr, w_addr;
  logic [LW-1:0]           r_len;
  logic                    r_full, r_rec_block;
  logic                    w_wr, w_rd, w_last_wr, w_last_rd;
  logic                    w_enter_rec, w_enter_play;
  logic [WIDTH-1:0]        r_mem [DEPTH];
  logic [WIDTH-1:0]        r_rd_data;
  logic signed [WIDTH-1:0] r_mic_q, r_data, w_s1_sample, w_avg;
  logic                    r_s1_play;
  logic [1:0]              r_vld_pipe;

  assign w_wr      = ready_in && (r_state == ST_RECORD);
  assign w_rd      = ready_in && (r_state == ST_PLAY);
  assign w_last_wr = w_wr && (r_len == LW'(DEPTH - 1));
  assign w_last_rd = (LW'(r_rd_ptr) == r_len - 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (record_in && !r_rec_block)              w_state_nxt = ST_RECORD;
        else if (!record_in && play_in && r_len != '0) w_state_nxt = ST_PLAY;
      end
      ST_RECORD: if (w_last_wr || !record_in) w_state_nxt = ST_IDLE;
      ST_PLAY:   if (!play_in || (w_rd && w_last_rd && !loop_in)) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_rec  = (r_state == ST_IDLE) && (w_state_nxt == ST_RECORD);
  assign w_enter_play = (r_state == ST_IDLE) && (w_state_nxt == ST_PLAY);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // A full buffer blocks re-entry to RECORD until record_in is released.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_len       <= '0;
      r_full      <= 1'b0;
      r_rec_block <= 1'b0;
    end else begin
      if (w_enter_rec) begin
        r_wr_ptr <= '0;
        r_len    <= '0;
        r_full   <= 1'b0;
      end else if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_len    <= r_len + 1'b1;
        if (w_last_wr) begin
          r_full      <= 1'b1;
          r_rec_block <= 1'b1;
        end
      end
      if (!record_in) r_rec_block <= 1'b0;

      if (w_enter_play)  r_rd_ptr <= '0;
      else if (w_rd)     r_rd_ptr <= (w_last_rd && loop_in) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  assign w_addr = (r_state == ST_RECORD) ? r_wr_ptr : r_rd_ptr;

  always_ff @(posedge clk_in) begin
    if (w_wr) r_mem[w_addr] <= mic_in;
    r_rd_data <= r_mem[w_addr];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mic_q    <= '0;
      r_s1_play  <= 1'b0;
      r_vld_pipe <= '0;
      r_data     <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], ready_in};
      if (ready_in) begin
        r_mic_q   <= mic_in;
        r_s1_play <= (r_state == ST_PLAY);
      end
      if (r_vld_pipe[0]) r_data <= filter_in ? w_avg : w_s1_sample;
    end
  end

  assign w_s1_sample = r_s1_play ? signed'(r_rd_data) : r_mic_q;

  boxcar_filter #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) u_filt (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .valid_in (r_vld_pipe[0]),
    .sample_in(w_s1_sample),
    .avg_out  (w_avg)
  );

  assign data_out   = r_data;
  assign valid_out  = r_vld_pipe[1];
  assign state_out  = r_state;
  assign length_out = r_len;
  assign full_out   = r_full;
endmodule

// File: tb/tb_sample_recorder.sv
// Directed table-driven bench for sample_recorder (WIDTH=8, DEPTH=16, AVG_LOG2=2).
module tb_sample_recorder;
  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              ready_in, record_in, play_in, loop_in, filter_in;
  logic signed [7:0] mic_in;
  logic signed [7:0] data_out;
  logic              valid_out;
  logic [1:0]        state_out;
  logic [4:0]        length_out;
  logic              full_out;

  int checks = 0;
  int failures = 0;

  sample_recorder #(.WIDTH(8), .DEPTH(16), .AVG_LOG2(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .ready_in(ready_in),
    .record_in(record_in), .play_in(play_in), .loop_in(loop_in),
    .filter_in(filter_in), .mic_in(mic_in), .data_out(data_out),
    .valid_out(valid_out), .state_out(state_out), .length_out(length_out),
    .full_out(full_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int mic;
    bit rec, play, loop, filt;
    int exp;
    int st;
    int len;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int mic, bit rec, bit play, bit loop, bit filt,
                              int exp, int st, int len);
    vec_t v;
    v.mic = mic; v.rec = rec; v.play = play; v.loop = loop; v.filt = filt;
    v.exp = exp; v.st = st; v.len = len;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Levels settle for two edges, one strobe, then the sample appears two edges after it.
  task automatic apply_vec(input vec_t v, input string nm);
    record_in = v.rec; play_in = v.play; loop_in = v.loop; filter_in = v.filt;
    repeat (2) @(posedge clk_in);
    #1;
    ready_in = 1'b1; mic_in = 8'(v.mic);
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    check({nm, " state"},  int'(state_out),  v.st);
    check({nm, " length"}, int'(length_out), v.len);
    check({nm, " early valid"}, int'(valid_out), 0);
    @(posedge clk_in); #1;
    check({nm, " valid"}, int'(valid_out), 1);
    check({nm, " data"},  int'(data_out),  v.exp);
  endtask

  task automatic strobe(input int mic);
    ready_in = 1'b1; mic_in = 8'(mic);
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " data"},   int'(data_out),   0);
    check({nm, " valid"},  int'(valid_out),  0);
    check({nm, " state"},  int'(state_out),  0);
    check({nm, " length"}, int'(length_out), 0);
    check({nm, " full"},   int'(full_out),   0);
  endtask

  initial begin
    rst_n_in = 1'b0; ready_in = 1'b0; record_in = 1'b0; play_in = 1'b0;
    loop_in = 1'b0; filter_in = 1'b0; mic_in = '0;

    // filter first so its delay line starts from zero
    tbl.push_back(mk( 4, 0,0,0,1,  1, 0,0));
    tbl.push_back(mk( 4, 0,0,0,1,  2, 0,0));
    tbl.push_back(mk( 4, 0,0,0,1,  3, 0,0));
    tbl.push_back(mk( 4, 0,0,0,1,  4, 0,0));
    tbl.push_back(mk(-8, 0,0,0,1,  1, 0,0));
    tbl.push_back(mk(-8, 0,0,0,1, -2, 0,0));
    // passthrough
    tbl.push_back(mk( 5, 0,0,0,0,  5, 0,0));
    tbl.push_back(mk(-7, 0,0,0,0, -7, 0,0));
    // record 4, output shows the live mic
    tbl.push_back(mk( 10, 1,0,0,0,  10, 1,1));
    tbl.push_back(mk( 20, 1,0,0,0,  20, 1,2));
    tbl.push_back(mk(-30, 1,0,0,0, -30, 1,3));
    tbl.push_back(mk( 40, 1,0,0,0,  40, 1,4));
    // play once; last read drops to IDLE but still emits
    tbl.push_back(mk(0, 0,1,0,0,  10, 2,4));
    tbl.push_back(mk(0, 0,1,0,0,  20, 2,4));
    tbl.push_back(mk(0, 0,1,0,0, -30, 2,4));
    tbl.push_back(mk(0, 0,1,0,0,  40, 0,4));
    tbl.push_back(mk(9, 0,0,0,0,   9, 0,4));
    // loop over 3 samples
    tbl.push_back(mk(1, 1,0,0,0, 1, 1,1));
    tbl.push_back(mk(2, 1,0,0,0, 2, 1,2));
    tbl.push_back(mk(3, 1,0,0,0, 3, 1,3));
    tbl.push_back(mk(0, 0,1,1,0, 1, 2,3));
    tbl.push_back(mk(0, 0,1,1,0, 2, 2,3));
    tbl.push_back(mk(0, 0,1,1,0, 3, 2,3));
    tbl.push_back(mk(0, 0,1,1,0, 1, 2,3));
    tbl.push_back(mk(0, 0,1,1,0, 2, 2,3));
    tbl.push_back(mk(0, 0,1,1,0, 3, 2,3));
    tbl.push_back(mk(0, 0,1,1,0, 1, 2,3));
    tbl.push_back(mk(-1, 0,0,0,0, -1, 0,3));

    #12;
    check_reset_outputs("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // Full: 20 strobes with record held, only 16 land
    record_in = 1'b1; play_in = 1'b0; loop_in = 1'b0; filter_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    for (int k = 0; k < 20; k++) strobe(100 + k);
    check("full state",  int'(state_out),  0);
    check("full length", int'(length_out), 16);
    check("full flag",   int'(full_out),   1);
    repeat (4) @(posedge clk_in);
    #1;
    check("full held state", int'(state_out), 0);

    // buffer did not wrap
    apply_vec(mk(0, 0,1,0,0, 100, 2,16), "fullplay0");
    apply_vec(mk(0, 0,1,0,0, 101, 2,16), "fullplay1");

    // re-arm after release clears full and length
    apply_vec(mk(55, 1,0,0,0, 55, 1,1), "rearm0");
    check("rearm full", int'(full_out), 0);
    apply_vec(mk(66, 1,0,0,0, 66, 1,2), "rearm1");
    apply_vec(mk(0, 0,1,0,0, 55, 2,2), "replay");

    // async reset mid-playback, away from any clock edge
    #2;
    rst_n_in = 1'b0;
    #1;
    check_reset_outputs("async");
    #3;
    rst_n_in = 1'b1;
    record_in = 1'b0; play_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("post reset state",  int'(state_out),  0);
    check("post reset length", int'(length_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
